// File: rtl/rf_pkg.sv
// Constants and types shared by the register file and its dump streamer.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [ADDR_W:0]   reg_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } dump_state_t;

endpackage

// File: rtl/rf_dump_streamer_if.sv
// Valid/ready word stream carrying dumped register values and their indices.
interface rf_dump_streamer_if;
    import rf_pkg::*;

    logic     out_valid;
    logic     out_ready;
    word_t    out_data;
    reg_idx_t out_index;
    logic     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/rf_out_stage.sv
// Single-entry output register: holds its word under backpressure, reloads on the handshake cycle.
module rf_out_stage
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  word_t    load_data,
    input  reg_idx_t load_index,
    input  logic     load_last,
    output logic     can_load,
    rf_dump_streamer_if.master strm
);

    assign can_load = !strm.out_valid || strm.out_ready;

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            strm.out_index <= '0;
            strm.out_last  <= 1'b0;
        end else if (load) begin
            strm.out_valid <= 1'b1;
            strm.out_data  <= load_data;
            strm.out_index <= load_index;
            strm.out_last  <= load_last;
        end else if (strm.out_valid && strm.out_ready) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_dump_streamer.sv
// Walks base_reg..base_reg+count-1 (mod NUM_REGS) through the RF read port and streams each word.
// Define RF_DUMP_CHECKSUM_EN to XOR-accumulate transferred words on the checksum output.
module rf_dump_streamer
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     start,
    input  reg_idx_t base_reg,
    input  reg_cnt_t count,
    output reg_idx_t rd_reg,
    input  word_t    rd_data,
    output logic     busy,
    output logic     done,
    output word_t    checksum,
    rf_dump_streamer_if.master strm
);

    dump_state_t state, state_next;
    reg_idx_t    ptr, ptr_next;
    reg_cnt_t    rem, rem_next;
    logic        done_next;
    logic        load;
    logic        can_load;
    logic        handshake;
    reg_cnt_t    count_clamped;
    reg_idx_t    ptr_inc;

    assign handshake     = strm.out_valid && strm.out_ready;
    assign count_clamped = (count > reg_cnt_t'(NUM_REGS)) ? reg_cnt_t'(NUM_REGS) : count;
    assign ptr_inc       = (ptr == reg_idx_t'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
    assign rd_reg        = ptr;
    assign busy          = (state != IDLE);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        rem_next   = rem;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        ptr_next   = base_reg;
                        rem_next   = count_clamped;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (can_load) begin
                    load     = 1'b1;
                    ptr_next = ptr_inc;
                    rem_next = rem - 1'b1;
                    if (rem == reg_cnt_t'(1)) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            rem   <= rem_next;
            done  <= done_next;
        end
    end

    rf_out_stage u_out_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (rd_data),
        .load_index (ptr),
        .load_last  (rem == reg_cnt_t'(1)),
        .can_load   (can_load),
        .strm       (strm)
    );

`ifdef RF_DUMP_CHECKSUM_EN
    word_t checksum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (state == IDLE && start) begin
            checksum_q <= '0;
        end else if (handshake) begin
            checksum_q <= checksum_q ^ strm.out_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
